// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter.
// Holds the default bus widths, the sequencer state encoding and the port-id
// constants used by dmem_arbiter and rr_arb2.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        StIdle   = 1'b0,
        StRdWait = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // The port that did not win; the pointer moves here after every grant.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// A lone requester always wins; under contention the pointer picks the
// winner, and every accepted grant moves the pointer to the loser.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset (pointer -> port 0)
//   req      request vector, bit n = port n
//   advance  a grant was taken this cycle; update the pointer
//   grant    one-hot grant (or zero when nothing requests)
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (ptr_q == PORT0) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (grant != 2'b00)) begin
            ptr_d = other_port(grant[1] ? PORT1 : PORT0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the 32x32 data RAM.
// Port 0 (CPU data) and port 1 (debug/DMA loader) share the RAM through a
// valid/ready request handshake. Writes complete in the grant cycle; reads
// hold the RAM enabled for one extra cycle (RAM data_out is only defined
// while ena=1) and return data on a registered one-cycle rvalid pulse.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   pX_valid/ready/we/addr/wdata    request channel of port X
//   pX_rvalid/rdata                 registered read response of port X
//   ram_ena/wena/addr/wdata         RAM control and write data
//   ram_rdata                       RAM read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_q, owner_d;

    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              granted;
    logic              win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Requests are only presented to the arbiter when a grant is possible, so
    // the pointer never moves in RD_WAIT or under reset.
    assign arb_req = (rst_n && (state_q == StIdle)) ? {p1_valid, p0_valid} : 2'b00;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (granted),
        .grant   (grant)
    );

    assign granted   = (grant != 2'b00);
    assign win_port  = grant[1] ? PORT1 : PORT0;
    assign win_we    = (win_port == PORT1) ? p1_we    : p0_we;
    assign win_addr  = (win_port == PORT1) ? p1_addr  : p0_addr;
    assign win_wdata = (win_port == PORT1) ? p1_wdata : p0_wdata;

    assign p0_ready = grant[0];
    assign p1_ready = grant[1];

    // Sequencer and RAM pin drive.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        owner_d   = owner_q;
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (granted) begin
                        ram_ena  = 1'b1;
                        ram_addr = win_addr;
                        if (win_we) begin
                            ram_wena  = 1'b1;
                            ram_wdata = win_wdata;
                        end else begin
                            state_d = StRdWait;
                            addr_d  = win_addr;
                            owner_d = win_port;
                        end
                    end
                end
                StRdWait: begin
                    // Keep the RAM enabled on the latched address so data_out
                    // is valid when it is captured at the end of this cycle.
                    ram_ena  = 1'b1;
                    ram_addr = addr_q;
                    state_d  = StIdle;
                end
            endcase
        end
    end

    // Read responses: one-cycle pulse to the owner, data held otherwise.
    always_comb begin
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        if (state_q == StRdWait) begin
            if (owner_q == PORT0) begin
                p0_rvalid_d = 1'b1;
                p0_rdata_d  = ram_rdata;
            end else begin
                p1_rvalid_d = 1'b1;
                p1_rdata_d  = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            owner_q     <= PORT0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            owner_q     <= owner_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
